// File: rtl/bridge_buf_pkg.sv
// bridge_buf_pkg: shared state encodings and the parameter consistency check for the ping-pong bridge buffer.
package bridge_buf_pkg;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAIN} bank_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_e;
  localparam int BANKS = 2;
  function automatic bit widths_ok(int w, int tiw, int iw, int tm, int mw, int depth);
    return w > 0 && tiw * iw == tm * mw && depth >= 2;
  endfunction
endpackage

// File: rtl/bridge_sdp_ram.sv
// bridge_sdp_ram: simple dual-port RAM with registered, synchronously cleared read output; {bank,addr} addressing rounds each bank up to a power of two.
module bridge_sdp_ram #(
  parameter int AW = 5,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/bridge_pingpong_buffer.sv
// bridge_pingpong_buffer: self-controlled two-bank tile buffer, wide beats in, module-width slices out.
// Optional BRIDGE_BUF_REPLAY_EN adds replay_num: each tile is drained replay_num+1 times.
module bridge_pingpong_buffer
  import bridge_buf_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int TOTAL_INPUT_W = 4,
  parameter int IN_WIDTH      = 32,
  parameter int TOTAL_MODULES = 4,
  parameter int MODULE_WIDTH  = 32,
  parameter int DEPTH         = 12,
  parameter int REPLAY_W      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_WIDTH-1:0]              in_data [TOTAL_INPUT_W],
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MODULE_WIDTH-1:0]          out_data,
  output logic [$clog2(TOTAL_MODULES)-1:0] out_slice,
  output logic                             out_last,
  output logic [1:0]                       bank_full
`ifdef BRIDGE_BUF_REPLAY_EN
  , input logic [REPLAY_W-1:0]             replay_num
`endif
);
  localparam int DW = TOTAL_INPUT_W * IN_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(TOTAL_MODULES);
  if (!widths_ok(WIDTH, TOTAL_INPUT_W, IN_WIDTH, TOTAL_MODULES, MODULE_WIDTH, DEPTH))
    $error("bridge_pingpong_buffer: inconsistent width/depth parameters");
  bank_state_e bank_q [BANKS];
  bank_state_e bank_d [BANKS];
  rd_state_e rstate_q, rstate_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [SW-1:0] slice_q, slice_d;
  logic [REPLAY_W-1:0] replay_q, replay_d, pass_q, pass_d, replay_in;
  logic [DW-1:0] wdata, rdata;
  logic [MODULE_WIDTH-1:0] slices [TOTAL_MODULES];
  logic [AW:0] raddr;
  logic re, wr_fire, rd_fire, slice_end, addr_end, final_pass, other_full;
`ifdef BRIDGE_BUF_REPLAY_EN
  assign replay_in = replay_num;
`else
  assign replay_in = '0;
`endif
  for (genvar i = 0; i < TOTAL_INPUT_W; i++) assign wdata[i*IN_WIDTH +: IN_WIDTH] = in_data[i];
  for (genvar s = 0; s < TOTAL_MODULES; s++) assign slices[s] = rdata[s*MODULE_WIDTH +: MODULE_WIDTH];
  bridge_sdp_ram #(.AW(AW + 1), .DW(DW)) u_ram (
    .clk(clk), .rst(rst),
    .we(wr_fire), .waddr({wr_bank_q, wr_addr_q}), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata)
  );
  always_comb begin
    in_ready   = !rst && (bank_q[wr_bank_q] == B_EMPTY || bank_q[wr_bank_q] == B_FILLING);
    wr_fire    = in_valid && in_ready;
    out_valid  = rstate_q == R_DRAIN;
    rd_fire    = out_valid && out_ready;
    slice_end  = slice_q == SW'(TOTAL_MODULES - 1);
    addr_end   = rd_addr_q == AW'(DEPTH - 1);
    final_pass = pass_q == replay_q;
    other_full = bank_q[!rd_bank_q] == B_FULL;
    out_last   = out_valid && slice_end && addr_end && final_pass;
    out_data   = out_valid ? slices[slice_q] : '0;
    out_slice  = slice_q;
    for (int b = 0; b < BANKS; b++) bank_full[b] = bank_q[b] == B_FULL || bank_q[b] == B_DRAIN;
  end
  always_comb begin
    bank_d    = bank_q;
    rstate_d  = rstate_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    slice_d   = slice_q;
    replay_d  = replay_q;
    pass_d    = pass_q;
    re        = 1'b0;
    raddr     = {rd_bank_q, {AW{1'b0}}};
    if (wr_fire) begin
      wr_addr_d         = wr_addr_q == AW'(DEPTH - 1) ? '0 : wr_addr_q + 1'b1;
      bank_d[wr_bank_q] = wr_addr_q == AW'(DEPTH - 1) ? B_FULL : B_FILLING;
      wr_bank_d         = wr_addr_q == AW'(DEPTH - 1) ? !wr_bank_q : wr_bank_q;
    end
    if (rstate_q == R_IDLE && bank_q[rd_bank_q] == B_FULL) begin
      re                = 1'b1;
      bank_d[rd_bank_q] = B_DRAIN;
      rstate_d          = R_DRAIN;
      rd_addr_d         = '0;
      slice_d           = '0;
      pass_d            = '0;
      replay_d          = replay_in;
    end else if (rd_fire) begin
      slice_d = slice_end ? '0 : slice_q + 1'b1;
      if (slice_end && !addr_end) begin
        re        = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        raddr     = {rd_bank_q, rd_addr_q + 1'b1};
      end else if (slice_end && !final_pass) begin
        re        = 1'b1;
        rd_addr_d = '0;
        pass_d    = pass_q + 1'b1;
      end else if (slice_end) begin
        // Release; if the other bank is already FULL start it now so the stream has no bubble.
        bank_d[rd_bank_q] = B_EMPTY;
        rd_bank_d         = !rd_bank_q;
        rd_addr_d         = '0;
        raddr             = {!rd_bank_q, {AW{1'b0}}};
        re                = other_full;
        pass_d            = '0;
        replay_d          = replay_in;
        rstate_d          = other_full ? R_DRAIN : R_IDLE;
        if (other_full) bank_d[!rd_bank_q] = B_DRAIN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q    <= '{default: B_EMPTY};
      rstate_q  <= R_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      slice_q   <= '0;
      replay_q  <= '0;
      pass_q    <= '0;
    end else begin
      bank_q    <= bank_d;
      rstate_q  <= rstate_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      slice_q   <= slice_d;
      replay_q  <= replay_d;
      pass_q    <= pass_d;
    end
  end
endmodule

// File: tb/tb_bridge_pingpong_buffer.sv
// tb_bridge_pingpong_buffer: directed plan plus random traffic against a tile-level queue model.
module tb_bridge_pingpong_buffer;
  localparam int TIW = 4, IW = 32, TM = 4, MW = 32, DEPTH = 12;
  typedef struct {logic [MW-1:0] d; int s; bit l;} exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [IW-1:0] in_data [TIW];
  logic in_ready, out_valid, out_last;
  logic [MW-1:0] out_data;
  logic [1:0] out_slice, bank_full;
  int n_cmp = 0, n_err = 0, f_tiles = 0, bc = 0, nhs = 0, gaps = 0, rp = 0;
  bit started, acc;
  logic [TIW*IW-1:0] tile_w [DEPTH];
  exp_t expq[$];
`ifdef BRIDGE_BUF_REPLAY_EN
  logic [3:0] replay_num = '0;
`endif
  always #5 clk = ~clk;
  bridge_pingpong_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_slice(out_slice), .out_last(out_last), .bank_full(bank_full)
`ifdef BRIDGE_BUF_REPLAY_EN
    , .replay_num(replay_num)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic rdy(int m, int c);
    return m == 0 ? 1'b1 : m == 1 ? logic'(c % 2 == 0) : m == 2 ? 1'b0 : logic'($urandom_range(1));
  endfunction
  // One clock: check against the model, apply handshakes to it, advance to posedge+1.
  task automatic cycle();
    int add = 0, rel = 0;
    logic [TIW*IW-1:0] w;
    exp_t e;
    #1;
    acc = 0;
    chk("in_ready", in_ready, f_tiles < 2);
    if (in_valid && in_ready) begin
      acc = 1;
      for (int i = 0; i < TIW; i++) w[i*IW +: IW] = in_data[i];
      tile_w[bc] = w;
      bc++;
      if (bc == DEPTH) begin
        for (int p = 0; p <= rp; p++)
          for (int a = 0; a < DEPTH; a++)
            for (int s = 0; s < TM; s++)
              expq.push_back('{tile_w[a][s*MW +: MW], s, p == rp && a == DEPTH-1 && s == TM-1});
        bc = 0;
        add = 1;
      end
    end
    if (out_valid) started = 1;
    else if (started && expq.size() > 0) gaps++;
    if (out_valid && expq.size() > 0) begin
      chk("out_data", out_data, expq[0].d);
      chk("out_slice", out_slice, expq[0].s);
      chk("out_last", out_last, expq[0].l);
    end
    if (out_valid && out_ready) begin
      nhs++;
      chk("queue_nonempty", expq.size() != 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.l) rel = 1;
        if (expq.size() == 0) started = 0;
      end
    end
    @(posedge clk);
    #1;
    f_tiles = f_tiles + add - rel;
  endtask
  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_slice", out_slice, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_in_ready", in_ready, 0);
    expq.delete();
    f_tiles = 0; bc = 0; started = 0; nhs = 0; gaps = 0;
    rst = 0;
  endtask
  task automatic feed(input int n, input int rmode, input int budget, output int got, output int cyc);
    got = 0; cyc = 0;
    while (got < n && cyc < budget) begin
      in_valid = 1;
      for (int i = 0; i < TIW; i++) in_data[i] = IW'(got * 4 + i);
      out_ready = rdy(rmode, cyc);
      cycle();
      if (acc) got++;
      cyc++;
    end
    in_valid = 0;
  endtask
  task automatic drain(input int rmode);
    int cyc = 0;
    while ((expq.size() > 0 || out_valid) && cyc < 4000) begin
      out_ready = rdy(rmode, cyc);
      cycle();
      cyc++;
    end
    chk("drain_done", expq.size(), 0);
  endtask
  initial begin
    int got, cyc;
    for (int i = 0; i < TIW; i++) in_data[i] = '0;
    // single tile
    do_reset();
    feed(12, 0, 100, got, cyc);
    chk("single_accepted", got, 12);
    chk("single_bank_full", bank_full, 2'b01);
    chk("single_valid_t1", out_valid, 0);
    out_ready = 1;
    cycle();
    chk("single_valid_t2", out_valid, 1);
    drain(0);
    chk("single_handshakes", nhs, 48);
    chk("single_gaps", gaps, 0);
    chk("single_released", bank_full, 0);
    // backpressure
    do_reset();
    feed(12, 1, 100, got, cyc);
    drain(1);
    chk("bp_handshakes", nhs, 48);
    // ping-pong
    do_reset();
    feed(24, 0, 100, got, cyc);
    chk("pp_cycles", cyc, 24);
    drain(0);
    chk("pp_handshakes", nhs, 96);
    chk("pp_gaps", gaps, 0);
    // full stall
    do_reset();
    feed(36, 2, 40, got, cyc);
    chk("stall_accepted", got, 24);
    chk("stall_bank_full", bank_full, 2'b11);
    feed(12, 0, 200, got, cyc);
    chk("stall_rest_accepted", got, 12);
    drain(0);
    chk("stall_handshakes", nhs, 144);
    // reset mid-drain
    do_reset();
    feed(12, 0, 100, got, cyc);
    cyc = 0;
    while (nhs < 20 && cyc < 200) begin
      out_ready = 1;
      cycle();
      cyc++;
    end
    chk("mid_reached", nhs, 20);
    do_reset();
    feed(12, 0, 100, got, cyc);
    drain(0);
    chk("mid_fresh_handshakes", nhs, 48);
`ifdef BRIDGE_BUF_REPLAY_EN
    replay_num = 2; rp = 2;
    do_reset();
    feed(12, 0, 100, got, cyc);
    drain(0);
    chk("replay_handshakes", nhs, 144);
    chk("replay_released", bank_full, 0);
    replay_num = 1; rp = 1;
`endif
    // random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      in_valid = logic'($urandom_range(1));
      for (int i = 0; i < TIW; i++) in_data[i] = $urandom;
      out_ready = logic'($urandom_range(3) != 0);
      cycle();
    end
    in_valid = 0;
    drain(3);
    chk("rand_partial_tile_only", bank_full, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
